ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 port. It sends one command byte to the mouse, for example 0xF4 (enable data reporting) or 0xFF (reset).
- It runs the full request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then samples the device ack.
- It sits beside the existing PS/2 receiver. The top level turns its open-drain enables into drives on PS2_CLK/PS2_DAT (line = oe ? 0 : z).
- The receiver is gated by busy while a frame is outgoing.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the PS/2 clock is held low (100 us at 50 MHz).
- RTS_TIMEOUT, 750000: max cycles from releasing clock to the first device falling edge (15 ms).
- BIT_TIMEOUT, 100000: max cycles between later device falling edges, and in WAIT_IDLE (2 ms).

Ports:
- clk, input, 1: system clock (CLOCK_50).
- reset, input, 1: synchronous, active-high.
- send, input, 1: request strobe; accepted only in IDLE.
- tx_byte, input, 8: command byte; latched on accept.
- ps2_clk_in, input, 1: raw PS2_CLK pin level (asynchronous).
- ps2_dat_in, input, 1: raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe, output, 1: 1 = pull PS2_CLK low.
- ps2_dat_oe, output, 1: 1 = pull PS2_DAT low.
- busy, output, 1: high from accept until done/err.
- done, output, 1: one-cycle pulse; byte acked, bus idle.
- err, output, 1: one-cycle pulse; timeout or NACK.

Behaviour:
- Reset (synchronous, active-high; any state, including mid-frame): next edge gives state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, err=0, all counters 0. Lines are released on that edge.
- Input conditioning: both pins pass through a 2-FF synchronizer. fall = sync_clk_prev & ~sync_clk. Detection lags the pin by 3 cycles.
- Parity: latched as odd parity, ~^tx_byte.
- IDLE: on send=1, latch tx_byte and parity, set busy=1, go to INHIBIT. send outside IDLE is ignored; no queueing, and the latched byte is unchanged.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: exactly 1 cycle with ps2_clk_oe=1 and ps2_dat_oe=1 (start bit; data goes low before clock is released). Then go to SHIFT with bit_idx=0 and the timeout counter cleared.
- SHIFT:
  - ps2_clk_oe=0. The timeout limit is RTS_TIMEOUT until the first fall, BIT_TIMEOUT afterwards; the counter clears on every fall.
  - Each fall increments bit_idx (k = new value). The cycle after detection drives ps2_dat_oe as follows:
    - k=1..8: ~tx_byte[k-1].
    - k=9: ~parity.
    - k=10: 0 (release line; stop bit = 1).
  - On fall with k=11, sample sync_dat: 0 (ACK) goes to WAIT_IDLE; 1 (NACK) goes to ERROR.
- WAIT_IDLE: wait until sync_clk=1 and sync_dat=1, then pulse done=1 for 1 cycle, set busy=0, go to IDLE. BIT_TIMEOUT applies here.
- ERROR (timeout in SHIFT/WAIT_IDLE, or NACK): the next cycle gives ps2_clk_oe=0, ps2_dat_oe=0, err=1 for 1 cycle, busy=0, go to IDLE. done and err are never both high.
- A timeout fires when the counter reaches its limit with no fall. The counter is wide enough for RTS_TIMEOUT with no wrap.
- ps2_clk_oe is high only in INHIBIT and REQ.
- No fall is acted on outside SHIFT. Glitches on the clock line during INHIBIT are ignored.

Decomposition:
- Package ps2_tx_pkg:
  - State enum: IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE, ERROR.
  - Constants: PS2_CMD_ENABLE_REPORTING=8'hF4, PS2_CMD_RESET=8'hFF, PS2_CMD_SET_DEFAULTS=8'hF6, PS2_RESP_ACK=8'hFA, PS2_FRAME_BITS=11.
- Sub-module ps2_line_sync: 2-FF synchronizers for clk and dat, plus the registered falling-edge strobe. It is reusable by the receiver.
- The FSM, shift/parity logic and timeout counter stay in ps2_host_tx.

Test Plan:
Bench uses INHIBIT_CYCLES=20, RTS_TIMEOUT=200, BIT_TIMEOUT=100, plus a device model that clocks with a 40-cycle period and samples data on rising edges.
- Send 0xF4 with the device acking. Required: clk_oe high for exactly 20 cycles; dat_oe high 1 cycle before clk_oe drops; device samples start 0, data 0,0,1,0,1,1,1,1, parity 0, stop 1; single done pulse, err=0, busy falls with done.
- Send 0x00. Required: parity bit 1; done pulse.
- Device never clocks. Required: err pulse exactly 200 cycles after clk_oe release; both oe=0; busy=0.
- Device drives data high at edge 11 (NACK). Required: err pulse, no done.
- send asserted again mid-frame with tx_byte=0xFF. Required: transmitted byte stays 0xF4; exactly one done.
- reset asserted at bit 5. Required: clk_oe, dat_oe, busy all 0 on the next edge, no pulses. A following send of 0xF6 completes with done.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// ps2_tx_pkg: shared types and constants for the PS/2 host transmitter.
//   - ps2_tx_state_e : transmitter FSM states
//   - PS2_CMD_* / PS2_RESP_ACK : common mouse command and response bytes
//   - PS2_FRAME_BITS : device clock falls in one host-to-device frame
//   - odd_parity()   : parity bit that makes data+parity contain an odd number of ones
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE,
    ERROR
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_ENABLE_REPORTING = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET            = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_DEFAULTS     = 8'hF6;
  localparam logic [7:0] PS2_RESP_ACK             = 8'hFA;
  localparam int         PS2_FRAME_BITS           = 11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a controller and ps2_host_tx.
//   send    : request strobe (master -> slave)
//   tx_byte : command byte, latched by the transmitter when send is accepted
//   busy    : transmitter owns the bus (slave -> master)
//   done    : one-cycle pulse, byte acknowledged and bus idle
//   err     : one-cycle pulse, timeout or NACK
interface ps2_host_tx_if;
  logic       send;
  logic [7:0] tx_byte;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output send, output tx_byte, input busy, input done, input err);
  modport slave  (input send, input tx_byte, output busy, output done, output err);
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// ps2_line_sync: conditions the raw PS/2 clock and data pins.
//   clk, reset         : system clock, synchronous active-high reset
//   clk_pin, dat_pin   : raw (asynchronous) PS2_CLK / PS2_DAT levels
//   sync_clk, sync_dat : pin levels after a 2-FF synchronizer
//   fall               : registered one-cycle strobe on a falling sync_clk;
//                        asserts 3 cycles after the pin falls
// Shared with the PS/2 receiver, so it carries no transmitter knowledge.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic sync_clk,
  output logic sync_dat,
  output logic fall
);

  logic [1:0] pin_in;
  logic [1:0] pin_sync;
  logic       clk_prev_reg;
  logic       fall_reg;

  assign pin_in = {dat_pin, clk_pin};

  // Synchronizer stages reset to 1, the idle level of an open-drain
  // bus, so leaving reset never looks like a falling edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= pin_in[gi];
        sync_reg <= meta_reg;
      end
    end

    assign pin_sync[gi] = sync_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev_reg <= 1'b1;
      fall_reg     <= 1'b0;
    end else begin
      clk_prev_reg <= pin_sync[0];
      fall_reg     <= clk_prev_reg & ~pin_sync[0];
    end
  end

  assign sync_clk = pin_sync[0];
  assign sync_dat = pin_sync[1];
  assign fall     = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Runs the request-to-send sequence: clock inhibit, start bit, 8 data bits
// LSB first, odd parity, stop bit, then samples the device ACK.
//   clk, reset             : system clock, synchronous active-high reset
//   cmd (slave)            : send / tx_byte in; busy / done / err out
//   ps2_clk_in, ps2_dat_in : raw pin levels (asynchronous)
//   ps2_clk_oe, ps2_dat_oe : open-drain enables, 1 = pull the line low
// Parameters are in clk cycles: clock inhibit length, wait for the first
// device clock after release, and wait between later device clocks
// (also the bound on the final bus-idle wait).
module ps2_host_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_TIMEOUT    = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic            clk,
  input  logic            reset,
  ps2_host_tx_if.slave    cmd,
  input  logic            ps2_clk_in,
  input  logic            ps2_dat_in,
  output logic            ps2_clk_oe,
  output logic            ps2_dat_oe
);

  // One counter serves inhibit timing and both timeouts, so size it for
  // the largest of them.
  localparam int CNT_MAX_A = (RTS_TIMEOUT > BIT_TIMEOUT) ? RTS_TIMEOUT : BIT_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > INHIBIT_CYCLES) ? CNT_MAX_A : INHIBIT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_TIMEOUT - 1);

  logic sync_clk;
  logic sync_dat;
  logic fall;

  ps2_line_sync u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_pin  (ps2_clk_in),
    .dat_pin  (ps2_dat_in),
    .sync_clk (sync_clk),
    .sync_dat (sync_dat),
    .fall     (fall)
  );

  ps2_tx_state_e    state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [3:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       data_reg,    data_next;
  logic             parity_reg,  parity_next;
  logic             clk_oe_reg,  clk_oe_next;
  logic             dat_oe_reg,  dat_oe_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;
  logic             err_reg,     err_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      data_reg    <= '0;
      parity_reg  <= 1'b0;
      clk_oe_reg  <= 1'b0;
      dat_oe_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      data_reg    <= data_next;
      parity_reg  <= parity_next;
      clk_oe_reg  <= clk_oe_next;
      dat_oe_reg  <= dat_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  logic [3:0]       k;           // bit_idx after the fall being handled
  logic [CNT_W-1:0] shift_last;  // last counter value before a SHIFT timeout
  logic             go_err;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    data_next    = data_reg;
    parity_next  = parity_reg;
    dat_oe_next  = dat_oe_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    go_err       = 1'b0;
    k            = bit_idx_reg + 4'd1;
    // Devices may take much longer to answer the request than to clock
    // later bits, so the first fall gets the longer limit.
    shift_last   = (bit_idx_reg == 4'd0) ? RTS_LAST : BIT_LAST;

    case (state_reg)
      IDLE: begin
        if (cmd.send) begin
          data_next   = cmd.tx_byte;
          parity_next = odd_parity(cmd.tx_byte);
          busy_next   = 1'b1;
          cnt_next    = '0;
          state_next  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_reg == INH_LAST) begin
          cnt_next    = '0;
          dat_oe_next = 1'b1;  // start bit goes low while clock is still held
          state_next  = REQ;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      REQ: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        state_next   = SHIFT;
      end

      SHIFT: begin
        if (fall) begin
          cnt_next     = '0;
          bit_idx_next = k;
          if (k <= 4'd8) begin
            dat_oe_next = ~data_reg[bit_idx_reg[2:0]];
          end else if (k == 4'd9) begin
            dat_oe_next = ~parity_reg;
          end else if (k == 4'd10) begin
            dat_oe_next = 1'b0;  // stop bit: release the line
          end else if (k == 4'(PS2_FRAME_BITS)) begin
            if (sync_dat) begin
              go_err = 1'b1;  // NACK: device left data high
            end else begin
              state_next = WAIT_IDLE;
            end
          end else begin
            go_err = 1'b1;
          end
        end else if (cnt_reg == shift_last) begin
          go_err = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        if (sync_clk && sync_dat) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (cnt_reg == BIT_LAST) begin
          go_err = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ERROR: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // ERROR is a one-cycle state; err is asserted during it, with the
    // lines already released and busy already low.
    if (go_err) begin
      state_next  = ERROR;
      err_next    = 1'b1;
      busy_next   = 1'b0;
      dat_oe_next = 1'b0;
      cnt_next    = '0;
    end

    // Clock enable is decoded from the next state so the pin is driven
    // straight from a flop.
    clk_oe_next = (state_next == INHIBIT) || (state_next == REQ);
  end

  assign ps2_clk_oe = clk_oe_reg;
  assign ps2_dat_oe = dat_oe_reg;
  assign cmd.busy   = busy_reg;
  assign cmd.done   = done_reg;
  assign cmd.err    = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_tx_pkg::*;

  localparam int INH = 20;
  localparam int RTS = 200;
  localparam int BIT = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if cmd_if ();

  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic dev_clk = 1'b1;
  logic dev_dat_low = 1'b0;

  // Open-drain wired lines: either side can pull low, otherwise pulled up.
  assign ps2_clk_in = ps2_clk_oe ? 1'b0 : dev_clk;
  assign ps2_dat_in = (ps2_dat_oe || dev_dat_low) ? 1'b0 : 1'b1;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_TIMEOUT    (RTS),
    .BIT_TIMEOUT    (BIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if.slave),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- monitor: cumulative event counts ----------------
  int   cyc = 0, done_total = 0, err_total = 0, both_total = 0;
  int   busy_at_done = 0, inh_total = 0, req_total = 0;
  int   rel_cyc = 0, err_cyc = 0;
  logic clk_oe_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    clk_oe_prev <= ps2_clk_oe;
    if (ps2_clk_oe && !ps2_dat_oe) inh_total <= inh_total + 1;
    if (ps2_clk_oe && ps2_dat_oe)  req_total <= req_total + 1;
    if (clk_oe_prev && !ps2_clk_oe) rel_cyc <= cyc;
    if (cmd_if.done) done_total <= done_total + 1;
    if (cmd_if.err) begin
      err_total <= err_total + 1;
      err_cyc   <= cyc;
    end
    if (cmd_if.done && cmd_if.err)  both_total   <= both_total + 1;
    if (cmd_if.done && cmd_if.busy) busy_at_done <= busy_at_done + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame as the device sees it: start 0, data LSB first,
  // parity making the count of ones in data+parity odd, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (ones % 2 == 0);
    f[10]   = 1'b1;
    return f;
  endfunction

  task automatic pulse_send(input logic [7:0] b);
    @(negedge clk);
    cmd_if.tx_byte = b;
    cmd_if.send    = 1'b1;
    @(negedge clk);
    cmd_if.send    = 1'b0;
  endtask

  // Device model: waits for the request (clock released, data low), then
  // clocks with a 40-cycle period sampling data on rising edges.
  task automatic device_xfer(input int abort_bit, input bit ack,
                             output logic [10:0] samp, output bit started);
    started = 1'b0;
    samp    = '0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_dat_oe) begin
        started = 1'b1;
        break;
      end
    end
    if (!started) return;
    samp[0] = ps2_dat_in;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      samp[i] = ps2_dat_in;
      if (i == abort_bit) return;
      repeat (10) @(negedge clk);
      if (i == 10 && ack) dev_dat_low = 1'b1;
      repeat (10) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_end(input int base, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done_total + err_total > base) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  tx;
    bit          ack;
    logic [10:0] exp_frame;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int d0, e0, i0, r0, b0, bd0;
    logic [10:0] samp;
    bit st, ok;
    d0 = done_total; e0 = err_total; i0 = inh_total;
    r0 = req_total;  b0 = both_total; bd0 = busy_at_done;
    pulse_send(v.tx);
    check("busy_after_accept", cmd_if.busy, 1);
    device_xfer(0, v.ack, samp, st);
    check("request_seen", st, 1);
    check("frame", samp, v.exp_frame);
    wait_end(d0 + e0, ok);
    check("end_in_time", ok, 1);
    check("inhibit_len", inh_total - i0, INH);
    check("req_len", req_total - r0, 1);
    check("done_count", done_total - d0, v.exp_done);
    check("err_count", err_total - e0, v.exp_err);
    check("done_err_overlap", both_total - b0, 0);
    check("busy_at_done", busy_at_done - bd0, 0);
    check("busy_after_end", cmd_if.busy, 0);
    check("oe_after_end", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    $display("frame tx=0x%02h ack=%0d sampled=0x%03h done=%0d err=%0d",
             v.tx, v.ack, samp, done_total - d0, err_total - e0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] samp;
    bit st, ok, seen;
    int d0, e0;
    logic [10:0] exp_f;

    cmd_if.send    = 1'b0;
    cmd_if.tx_byte = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_dat_oe", ps2_dat_oe, 0);
    check("reset_busy", cmd_if.busy, 0);
    check("reset_done", cmd_if.done, 0);
    check("reset_err", cmd_if.err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Fixed rows carry hand-derived frames; random rows use the model.
    vecs[0] = '{PS2_CMD_ENABLE_REPORTING, 1'b1, 11'h5E8, 1, 0};
    vecs[1] = '{8'h00,                    1'b1, 11'h600, 1, 0};
    vecs[2] = '{PS2_CMD_RESET,            1'b1, 11'h7FE, 1, 0};
    vecs[3] = '{PS2_CMD_SET_DEFAULTS,     1'b0, 11'h7EC, 0, 1};
    vecs[4] = '{PS2_RESP_ACK,             1'b1, 11'h7F4, 1, 0};
    for (int i = 5; i < 10; i++) begin
      vecs[i].tx        = 8'($urandom_range(0, 255));
      vecs[i].ack       = ($urandom_range(0, 3) != 0);
      vecs[i].exp_frame = ref_frame(vecs[i].tx);
      vecs[i].exp_done  = vecs[i].ack ? 1 : 0;
      vecs[i].exp_err   = vecs[i].ack ? 0 : 1;
    end
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      repeat (10) @(negedge clk);
    end

    // Device never clocks: RTS timeout.
    d0 = done_total; e0 = err_total;
    pulse_send(8'h11);
    seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (cmd_if.err) begin
        seen = 1'b1;
        check("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("timeout_busy", cmd_if.busy, 0);
        break;
      end
    end
    check("timeout_seen", seen, 1);
    repeat (3) @(negedge clk);
    check("timeout_latency", err_cyc - rel_cyc, RTS);
    check("timeout_err_count", err_total - e0, 1);
    check("timeout_no_done", done_total - d0, 0);
    $display("timeout err latency=%0d", err_cyc - rel_cyc);
    repeat (10) @(negedge clk);

    // send during a frame is ignored; the latched byte stays.
    d0 = done_total; e0 = err_total;
    pulse_send(PS2_CMD_ENABLE_REPORTING);
    fork
      device_xfer(0, 1'b1, samp, st);
      begin
        repeat (150) @(negedge clk);
        cmd_if.tx_byte = 8'hFF;
        cmd_if.send    = 1'b1;
        @(negedge clk);
        cmd_if.send    = 1'b0;
      end
    join
    check("midsend_frame", samp, ref_frame(PS2_CMD_ENABLE_REPORTING));
    wait_end(d0 + e0, ok);
    check("midsend_end", ok, 1);
    repeat (100) @(negedge clk);
    check("midsend_done_count", done_total - d0, 1);
    check("midsend_err_count", err_total - e0, 0);
    check("midsend_no_queue", cmd_if.busy, 0);
    $display("midframe send sampled=0x%03h done=%0d", samp, done_total - d0);

    // Reset in the middle of bit 5.
    d0 = done_total; e0 = err_total;
    pulse_send(PS2_CMD_ENABLE_REPORTING);
    device_xfer(5, 1'b1, samp, st);
    exp_f = ref_frame(PS2_CMD_ENABLE_REPORTING);
    check("reset_partial_frame", samp[5:0], exp_f[5:0]);
    check("busy_before_reset", cmd_if.busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_clk_oe", ps2_clk_oe, 0);
    check("midreset_dat_oe", ps2_dat_oe, 0);
    check("midreset_busy", cmd_if.busy, 0);
    check("midreset_pulses", {cmd_if.done, cmd_if.err}, 2'b00);
    repeat (50) @(negedge clk);
    check("midreset_no_done", done_total - d0, 0);
    check("midreset_no_err", err_total - e0, 0);
    $display("reset at bit 5 released lines");
    run_vec('{PS2_CMD_SET_DEFAULTS, 1'b1, ref_frame(PS2_CMD_SET_DEFAULTS), 1, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
